deserializer_fsm: RTL and testbench

Serial-to-parallel counterpart of the FIR datapath's bit serializer. Accepts a stream of single bits, LSB first, under a valid/ready handshake and assembles LENGTH-bit words. Presents each word on a parallel output with its own valid/ready handshake. Double-buffered: the next word is received while the previous word waits for the consumer. An optional inactivity timeout discards partial words.

---
 rtl/deserializer_fsm.sv | 162 ++++++++++++++++
 tb/tb_deserializer_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/deserializer_fsm.sv
// deserializer_fsm
//   Serial-to-parallel converter. Single bits arrive LSB first under a
//   valid/ready handshake and are assembled into LENGTH-bit words, which are
//   presented on a parallel output with their own valid/ready handshake.
//   A completed word can wait in the shift register while the previous word
//   is still unconsumed, so the consumer sees back-to-back words. With
//   TIMEOUT > 0 a partial word that stalls for TIMEOUT enabled cycles is
//   discarded and o_err pulses.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset (overrides i_en)
//   i_en         clock enable; all registers hold while low
//   i_din        serial data bit, LSB of word first
//   i_din_valid  i_din is valid
//   o_ready      a bit can be accepted this cycle (combinational)
//   ov_dout      assembled word
//   o_dout_valid ov_dout holds an unconsumed word
//   i_ready      consumer takes ov_dout this cycle when o_dout_valid=1
//   o_err        one-cycle pulse: partial word discarded on timeout
module deserializer_fsm #(
  parameter int unsigned LENGTH  = 24,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_err
);

  localparam int unsigned CW = $clog2(LENGTH) + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(LENGTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [LENGTH-1:0] sr, sr_n;
  logic [LENGTH-1:0] dout, dout_n;
  logic              dv, dv_n;
  logic              err, err_n;
  logic [LENGTH-1:0] word;
  logic              acc;
  logic              drain;

  assign o_ready      = i_en && (state != S_STALL);
  assign acc          = i_en && i_din_valid && o_ready;
  assign drain        = i_en && dv && i_ready;
  assign ov_dout      = dout;
  assign o_dout_valid = dv;
  assign o_err        = err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      sr    <= '0;
      dout  <= '0;
      dv    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
      sr    <= sr_n;
      dout  <= dout_n;
      dv    <= dv_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    sr_n    = sr;
    dout_n  = dout;
    dv_n    = dv;
    err_n   = err;
    word    = {i_din, sr[LENGTH-1:1]};

    if (i_en) begin
      err_n = 1'b0;
      // A drain clears valid unless a load below re-asserts it on the same edge.
      if (drain) dv_n = 1'b0;

      case (state)
        S_IDLE: begin
          cnt_n  = '0;
          tcnt_n = '0;
          if (acc) begin
            sr_n    = word;
            cnt_n   = CW'(1);
            state_n = S_RECV;
          end
        end

        S_RECV: begin
          if (acc) begin
            tcnt_n = '0;
            sr_n   = word;
            if (cnt == C_LAST) begin
              cnt_n = '0;
              if (!dv || drain) begin
                dout_n  = word;
                dv_n    = 1'b1;
                state_n = S_IDLE;
              end else begin
                // Output still occupied: park the finished word in sr.
                state_n = S_STALL;
              end
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if ((TIMEOUT > 0) && !i_din_valid) begin
            if (tcnt == T_LAST) begin
              cnt_n   = '0;
              tcnt_n  = '0;
              sr_n    = '0;
              err_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end

        S_STALL: begin
          if (drain) begin
            // Hand the parked word straight to the output; valid stays high.
            dout_n  = sr;
            dv_n    = 1'b1;
            sr_n    = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end

        default: begin
          cnt_n   = '0;
          tcnt_n  = '0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Directed bench for deserializer_fsm (LENGTH=24, TIMEOUT=4). Expected words
// are queued when a word is driven and compared when the consumer drains one.
module tb_deserializer_fsm;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_din;
  logic        i_din_valid;
  logic        o_ready;
  logic [23:0] ov_dout;
  logic        o_dout_valid;
  logic        i_ready;
  logic        o_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  deserializer_fsm #(.LENGTH(24), .TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .o_ready     (o_ready),
    .ov_dout     (ov_dout),
    .o_dout_valid(o_dout_valid),
    .i_ready     (i_ready),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle from a negedge; drains are scored before the edge,
  // and the task returns at the next negedge with post-edge state visible.
  task automatic cyc(input logic en, input logic din, input logic dv,
                     input logic rdy, output logic rdy_seen);
    logic [23:0] exp;
    i_en = en; i_din = din; i_din_valid = dv; i_ready = rdy;
    #1;
    rdy_seen = o_ready;
    if (en && rdy && o_dout_valid && !i_rst) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL sb_spurious: got word %0h expected none", ov_dout);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("sb_word", 32'(ov_dout), 32'(exp));
      end
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input logic rdy, input logic chk_rdy);
    logic r;
    sb.push_back(w);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, w[i], 1'b1, rdy, r);
      if (chk_rdy) chk("ready_in_word", 32'(r), 32'd1);
    end
  endtask

  task automatic do_reset();
    logic r;
    i_rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, r);
    i_rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic        r;
    logic [23:0] w;

    i_rst = 1'b1; i_en = 1'b0; i_din = 1'b0; i_din_valid = 1'b0; i_ready = 1'b0;
    @(negedge clk);

    // 1: reset values, then one word with the consumer always ready
    do_reset();
    do_reset();
    chk("rst_valid", 32'(o_dout_valid), 32'd0);
    chk("rst_dout", 32'(ov_dout), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    send_word(24'hA5C3F1, 1'b1, 1'b1);
    chk("t1_valid_lat", 32'(o_dout_valid), 32'd1);
    chk("t1_dout", 32'(ov_dout), 32'hA5C3F1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t1_valid_drop", 32'(o_dout_valid), 32'd0);
    chk("t1_dout_hold", 32'(ov_dout), 32'hA5C3F1);

    // 2: second word stalls behind the first, 25th bit refused
    send_word(24'h123456, 1'b0, 1'b0);
    chk("t2_valid1", 32'(o_dout_valid), 32'd1);
    send_word(24'hABCDEF, 1'b0, 1'b0);
    chk("t2_stall_ready", 32'(o_ready), 32'd0);
    chk("t2_hold_dout", 32'(ov_dout), 32'h123456);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, r);
    chk("t2_bit25_refused", 32'(r), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t2_next_dout", 32'(ov_dout), 32'hABCDEF);
    chk("t2_valid_kept", 32'(o_dout_valid), 32'd1);
    chk("t2_ready_back", 32'(o_ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t2_valid_drop", 32'(o_dout_valid), 32'd0);

    // 3: completion on the same edge as a drain of the prior word
    send_word(24'h000001, 1'b0, 1'b0);
    w = 24'h3C3C3C;
    sb.push_back(w);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, w[i], 1'b1, (i == 23), r);
      chk("t3_valid_no_drop", 32'(o_dout_valid), 32'd1);
    end
    chk("t3_dout", 32'(ov_dout), 32'h3C3C3C);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);

    // 4: timeout on a partial word leaves the output register alone
    send_word(24'h777777, 1'b0, 1'b0);
    w = 24'h0002AB;
    for (int i = 0; i < 10; i++) cyc(1'b1, w[i], 1'b1, 1'b0, r);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, r);
      chk("t4_err_early", 32'(o_err), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, r);
    chk("t4_err_pulse", 32'(o_err), 32'd1);
    chk("t4_valid_kept", 32'(o_dout_valid), 32'd1);
    chk("t4_dout_kept", 32'(ov_dout), 32'h777777);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t4_err_clear", 32'(o_err), 32'd0);
    send_word(24'h0F0F0F, 1'b1, 1'b0);
    chk("t4_dout_after", 32'(ov_dout), 32'h0F0F0F);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);

    // 5: enable toggling; disabled cycles carry junk bits and a ready consumer
    send_word(24'h111111, 1'b0, 1'b0);
    w = 24'h800001;
    sb.push_back(w);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, ~w[i], 1'b1, 1'b1, r);
      chk("t5_ready_en_low", 32'(r), 32'd0);
      chk("t5_valid_en_low", 32'(o_dout_valid), 32'd1);
      cyc(1'b1, w[i], 1'b1, 1'b0, r);
    end
    chk("t5_stall", 32'(o_ready), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t5_dout", 32'(ov_dout), 32'h800001);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("t5_valid_drop", 32'(o_dout_valid), 32'd0);

    // 6: reset mid-word and while stalled
    w = 24'hFFFFFF;
    for (int i = 0; i < 12; i++) cyc(1'b1, w[i], 1'b1, 1'b1, r);
    do_reset();
    chk("t6a_valid", 32'(o_dout_valid), 32'd0);
    chk("t6a_ready", 32'(o_ready), 32'd1);
    send_word(24'h246813, 1'b0, 1'b0);
    send_word(24'h13579B, 1'b0, 1'b0);
    chk("t6_pre_stall", 32'(o_ready), 32'd0);
    do_reset();
    chk("t6b_valid", 32'(o_dout_valid), 32'd0);
    chk("t6b_dout", 32'(ov_dout), 32'd0);
    chk("t6b_ready", 32'(o_ready), 32'd1);
    send_word(24'h5A5A5A, 1'b1, 1'b0);
    chk("t6_dout", 32'(ov_dout), 32'h5A5A5A);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
